// File: rtl/rc4_pkg.sv
// RC4 shared types.
// Holds the PRGA decryptor FSM state encoding that is exported on state_tap.
package rc4_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    NEXT_I    = 4'd1,
    WAIT_SI   = 4'd2,
    READ_SI   = 4'd3,
    WAIT_SJ   = 4'd4,
    READ_SJ   = 4'd5,
    WRITE_I   = 4'd6,
    WRITE_J   = 4'd7,
    WAIT_F    = 4'd8,
    READ_F    = 4'd9,
    WRITE_OUT = 4'd10
  } state_t;

endpackage

// File: rtl/trap_edge.sv
// Rising-edge detector.
// The rise output is high while sig is 1 and was 0 at the previous clock edge.
module trap_edge (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sig_q <= 1'b0;
    else       sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/prga_decryptor.sv
// RC4 PRGA keystream generator with XOR decryption into plaintext RAM.
// Takes over the S RAM port after the KSA shuffler completes.
module prga_decryptor
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH      = 8,
  parameter int RAM_LENGTH     = 8,
  parameter int MSG_LENGTH     = 32,
  parameter int MSG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      finished,
  input  logic [RAM_WIDTH-1:0]      s_q,
  output logic [RAM_LENGTH-1:0]     s_addr,
  output logic [RAM_WIDTH-1:0]      s_data,
  output logic                      s_wren,
  output logic [MSG_ADDR_WIDTH-1:0] rom_addr,
  input  logic [RAM_WIDTH-1:0]      rom_q,
  output logic [MSG_ADDR_WIDTH-1:0] out_addr,
  output logic [RAM_WIDTH-1:0]      out_data,
  output logic                      out_wren,
  output logic [3:0]                state_tap
);

  localparam logic [MSG_ADDR_WIDTH-1:0] K_LAST =
    MSG_ADDR_WIDTH'(MSG_LENGTH - 1);

  state_t                    state, state_n;
  logic [RAM_LENGTH-1:0]     i, i_n, j, j_n;
  logic [MSG_ADDR_WIDTH-1:0] k, k_n;
  logic [RAM_WIDTH-1:0]      si, si_n, sj, sj_n;
  logic [RAM_LENGTH-1:0]     s_addr_n;
  logic [RAM_WIDTH-1:0]      s_data_n, out_data_n;
  logic                      s_wren_n, out_wren_n, fin_n;
  logic [MSG_ADDR_WIDTH-1:0] rom_addr_n, out_addr_n;
  logic                      start_rise;

  trap_edge u_start_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (start),
    .rise  (start_rise)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      si       <= '0;
      sj       <= '0;
      s_addr   <= '0;
      s_data   <= '0;
      s_wren   <= 1'b0;
      rom_addr <= '0;
      out_addr <= '0;
      out_data <= '0;
      out_wren <= 1'b0;
      finished <= 1'b0;
    end else begin
      state    <= state_n;
      i        <= i_n;
      j        <= j_n;
      k        <= k_n;
      si       <= si_n;
      sj       <= sj_n;
      s_addr   <= s_addr_n;
      s_data   <= s_data_n;
      s_wren   <= s_wren_n;
      rom_addr <= rom_addr_n;
      out_addr <= out_addr_n;
      out_data <= out_data_n;
      out_wren <= out_wren_n;
      finished <= fin_n;
    end
  end

  always_comb begin
    state_n    = state;
    i_n        = i;
    j_n        = j;
    k_n        = k;
    si_n       = si;
    sj_n       = sj;
    s_addr_n   = s_addr;
    s_data_n   = s_data;
    s_wren_n   = s_wren;
    rom_addr_n = rom_addr;
    out_addr_n = out_addr;
    out_data_n = out_data;
    out_wren_n = out_wren;
    fin_n      = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) begin
          i_n     = '0;
          j_n     = '0;
          k_n     = '0;
          state_n = NEXT_I;
        end
      end
      NEXT_I: begin
        i_n        = i + 1'b1;
        s_addr_n   = i + 1'b1;
        rom_addr_n = k;
        state_n    = WAIT_SI;
      end
      WAIT_SI: state_n = READ_SI;
      READ_SI: begin
        si_n     = s_q;
        j_n      = j + RAM_LENGTH'(s_q);
        s_addr_n = j + RAM_LENGTH'(s_q);
        state_n  = WAIT_SJ;
      end
      WAIT_SJ: state_n = READ_SJ;
      READ_SJ: begin
        sj_n     = s_q;
        s_addr_n = i;
        s_data_n = s_q;
        s_wren_n = 1'b1;
        state_n  = WRITE_I;
      end
      WRITE_I: begin
        s_addr_n = j;
        s_data_n = si;
        s_wren_n = 1'b1;
        state_n  = WRITE_J;
      end
      // Writes are done; the f lookup address is latched for WAIT_F.
      WRITE_J: begin
        s_wren_n = 1'b0;
        s_data_n = '0;
        s_addr_n = RAM_LENGTH'(si + sj);
        state_n  = WAIT_F;
      end
      WAIT_F: state_n = READ_F;
      READ_F: begin
        out_addr_n = k;
        out_data_n = s_q ^ rom_q;
        out_wren_n = 1'b1;
        state_n    = WRITE_OUT;
      end
      WRITE_OUT: begin
        out_wren_n = 1'b0;
        if (k == K_LAST) begin
          fin_n   = 1'b1;
          state_n = IDLE;
        end else begin
          k_n     = k + 1'b1;
          state_n = NEXT_I;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign state_tap = state;

endmodule

// File: doc/prga_decryptor.md
Name: prga_decryptor

Overview:
RC4 keystream-generation (PRGA) and XOR decryption stage. It runs after the KSA shuffler has finished permuting the S working RAM, and it takes ownership of the S RAM port once the shuffler asserts finished. For each ciphertext byte k it performs the i/j update and the S swap, then reads f = S[(S[i]+S[j]) mod 256]. It writes f XOR ct[k] to the plaintext RAM and pulses finished once the whole message is done.

Parameters:
RAM_WIDTH, 8, data width of the S RAM, ciphertext ROM and plaintext RAM.
RAM_LENGTH, 8, S RAM address width (256 entries).
MSG_LENGTH, 32, number of message bytes to decrypt (>=1).
MSG_ADDR_WIDTH, 5, address width of the ciphertext ROM and plaintext RAM (2^MSG_ADDR_WIDTH >= MSG_LENGTH).

Ports:
clk  in  1  single clock; all logic is rising-edge.
reset  in  1  asynchronous, active-high; clears all state and outputs.
start  in  1  level input; rising edge launches decryption; edge-detected internally.
finished  out  1  one-cycle pulse when the last plaintext byte has been written.
s_q  in  RAM_WIDTH  S RAM read data.
s_addr  out  RAM_LENGTH  S RAM address.
s_data  out  RAM_WIDTH  S RAM write data.
s_wren  out  1  S RAM write enable.
rom_addr  out  MSG_ADDR_WIDTH  ciphertext ROM address.
rom_q  in  RAM_WIDTH  ciphertext ROM read data.
out_addr  out  MSG_ADDR_WIDTH  plaintext RAM address.
out_data  out  RAM_WIDTH  plaintext RAM write data.
out_wren  out  1  plaintext RAM write enable.
state_tap  out  4  current FSM state, for test.

Behaviour:
- Reset (async, active-high): state=IDLE; i, j, k, si, sj = 0; every registered output = 0.
- All memory-facing outputs are registered. Memories have synchronous reads, and read data is sampled exactly two clocks after the address register updates (one WAIT state).
- i, j and the S address are RAM_LENGTH bits wide and wrap mod 256. k is MSG_ADDR_WIDTH bits wide.
- IDLE: on start rising edge, clear i, j, k to 0 and go to NEXT_I. Any other start activity is ignored, including a start edge while busy.
- NEXT_I: i<=i+1; s_addr<=i+1; rom_addr<=k; go to WAIT_SI.
- WAIT_SI: go to READ_SI.
- READ_SI: si<=s_q; j<=j+s_q; s_addr<=j+s_q; go to WAIT_SJ.
- WAIT_SJ: go to READ_SJ.
- READ_SJ: sj<=s_q; s_addr<=i; s_data<=s_q; s_wren<=1; go to WRITE_I.
- WRITE_I: s_addr<=j; s_data<=si; s_wren<=1; go to WRITE_J.
- WRITE_J: s_wren<=0; s_data<=0; s_addr<=si+sj (mod 256); go to WAIT_F.
- WAIT_F: go to READ_F.
- READ_F: out_addr<=k; out_data<=s_q^rom_q; out_wren<=1; go to WRITE_OUT.
- WRITE_OUT: out_wren<=0.
  - If k==MSG_LENGTH-1: finished<=1; go to IDLE.
  - Otherwise: k<=k+1; go to NEXT_I.
- finished is high for exactly the first IDLE cycle after completion, then returns to 0.
- Timing: 10 cycles per byte. From the cycle the start edge is detected to finished high is 10*MSG_LENGTH+1 cycles.
- s_wren is high for exactly 2 consecutive cycles per byte, presenting (addr i, data sj) then (addr j, data si). out_wren is high for exactly 1 cycle per byte.
- i==j case: both writes target the same address with the same value, so S is unchanged. No special handling.
- rom_addr is stable from NEXT_I through READ_F, so rom_q is valid at READ_F.
- Reset mid-operation returns to IDLE immediately. The S RAM is not restored; the caller must re-run the shuffler before restarting.
- Undefined state encodings go to IDLE.

Decomposition:
- Shared package rc4_pkg holds the state_t enum for this block's FSM (11 states, 4-bit encoding, used by state_tap).
- One sub-module: instantiate the team's trap_edge edge detector on start. No other hierarchy.

Test Plan:
1. Identity-load S (S[x]=x), MSG_LENGTH=3, ct={0x43,0x60,0x66}, pulse start. Required keystream 0x02,0x05,0x07 and out={0x41,0x65,0x61} at addrs 0,1,2. finished pulses exactly 31 cycles after the start edge is detected.
2. Same setup; check the S RAM writes. Byte0 writes S[1]=1 twice (i==j=1). Byte1 writes S[2]=3, S[3]=2. Byte2 writes S[3]=5, S[5]=2.
3. Assert async reset mid-byte (during WAIT_SJ). All outputs go to 0 before the next clock edge and state_tap reads IDLE. A fresh start (after reloading identity S) reproduces scenario 1.
4. Toggle start repeatedly while busy. Output is identical to scenario 1 and there is exactly one finished pulse.
5. MSG_LENGTH=32 with an S RAM preloaded from a KSA run with key {0x00,0x03,0x3C}. All 32 out bytes match a software RC4 reference, out_wren pulses exactly 32 times, and k wraps cleanly with no write to address 32.
6. Hold start high after finished. No new run starts until start goes low and then high again.
